// File: rtl/me_block_scheduler.sv
// me_block_scheduler: walks a frame of macroblocks through memory load, full search and result capture,
// queueing each block's best match in a small first-word-fall-through buffer.
module me_block_scheduler #(
  parameter int SEARCH_CYCLES = 4112,
  parameter int RES_DEPTH = 4,
  parameter int BLK_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [BLK_W-1:0] num_blocks,
  output logic             load_req,
  input  logic             load_ack,
  output logic [BLK_W-1:0] block_idx,
  output logic             me_start,
  input  logic [7:0]       BestDist,
  input  logic [3:0]       motionX,
  input  logic [3:0]       motionY,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BLK_W-1:0] res_block,
  output logic [7:0]       res_dist,
  output logic [3:0]       res_mx,
  output logic [3:0]       res_my,
  output logic             busy,
  output logic             frame_done
);
  localparam int AW = $clog2(RES_DEPTH);
  localparam int EW = BLK_W + 16;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, CAPTURE, DONE} state_t;
  state_t state;
  logic [BLK_W-1:0] nblk;
  logic [12:0] cyc;
  logic [EW-1:0] mem [RES_DEPTH];
  logic [AW-1:0] wptr, rptr, head;
  logic [AW:0] count;
  logic full, push, pop;
  assign full = count == (AW+1)'(RES_DEPTH);
  assign push = state == CAPTURE && !full;
  assign pop = res_valid && res_ready;
  assign res_valid = count != '0;
  // when empty, point at the most recently popped entry so the outputs hold steady
  assign head = res_valid ? rptr : rptr - 1'b1;
  assign {res_block, res_dist, res_mx, res_my} = mem[head];
  assign load_req = state == LOAD;
  assign me_start = state == RUN;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      nblk <= '0;
      block_idx <= '0;
      cyc <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < RES_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {block_idx, BestDist, motionX, motionY};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE: if (frame_start) begin
          nblk <= num_blocks;
          block_idx <= '0;
          state <= num_blocks == '0 ? DONE : LOAD;
        end
        LOAD: if (load_ack) begin
          cyc <= '0;
          state <= RUN;
        end
        RUN: begin
          cyc <= cyc + 1'b1;
          if (cyc == 13'(SEARCH_CYCLES - 1)) state <= SETTLE;
        end
        SETTLE: state <= CAPTURE;
        // a full buffer stalls here; the core holds its outputs while me_start is low
        CAPTURE: if (push) begin
          if (block_idx == nblk - 1'b1) state <= DONE;
          else begin
            block_idx <= block_idx + 1'b1;
            state <= LOAD;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
